// File: rtl/perip_pkg.sv
// -----------------------------------------------------------------------------
// perip_pkg
// Shared definitions for the peripheral duty-ramp blocks.
//   ramp_state_e : FSM state encoding (IDLE, RAMP)
//   DUTY_W       : default duty width
//   STEP_MIN     : smallest step size; a programmed step of 0 maps to this
//   eff_step()   : applies the zero-step substitution
// -----------------------------------------------------------------------------
package perip_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_e;

    localparam int          DUTY_W   = 32;
    localparam logic [15:0] STEP_MIN = 16'd1;

    // A step of zero would stall the ramp forever, so it is promoted to STEP_MIN.
    function automatic logic [15:0] eff_step(input logic [15:0] step_raw);
        logic [15:0] step_eff;
        if (step_raw == 16'd0) begin
            step_eff = STEP_MIN;
        end else begin
            step_eff = step_raw;
        end
        return step_eff;
    endfunction

endpackage

// File: rtl/perip_ramp_step.sv
// -----------------------------------------------------------------------------
// perip_ramp_step
// Combinational saturating step of a duty value toward a target.
//   cur       in  WIDTH : present duty
//   tgt       in  WIDTH : target duty
//   step      in  16    : step size (0 treated as 1)
//   nxt       out WIDTH : duty after one step, never past tgt
//   at_target out 1     : nxt equals tgt
// -----------------------------------------------------------------------------
module perip_ramp_step
    import perip_pkg::*;
#(
    parameter int WIDTH = DUTY_W
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [15:0]      step,
    output logic [WIDTH-1:0] nxt,
    output logic             at_target
);

    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] step_s;
    logic             up_s;

    // Distance to target and direction; clamp to target when within one step.
    always_comb begin
        up_s   = (tgt >= cur);
        step_s = WIDTH'(eff_step(step));
        if (up_s) begin
            diff_s = tgt - cur;
        end else begin
            diff_s = cur - tgt;
        end

        if (diff_s <= step_s) begin
            nxt = tgt;
        end else if (up_s) begin
            nxt = cur + step_s;
        end else begin
            nxt = cur - step_s;
        end

        at_target = (nxt == tgt);
    end

endmodule

// File: rtl/perip_duty_ramp.sv
// -----------------------------------------------------------------------------
// perip_duty_ramp
// Soft-start ramp between a register-file duty target and a PWM duty input.
// Duty_Out walks toward Target_Set by Step_Set every Rate_Set+1 cycles.
//   CLK        in  1     : system clock
//   RST        in  1     : synchronous active-high reset
//   Ramp_En    in  1     : 1 = ramp, 0 = bypass (Duty_Out follows target)
//   Target_Set in  WIDTH : requested duty (already CLK-synchronous)
//   Rate_Set   in  32    : cycles between steps minus one
//   Step_Set   in  16    : duty change per step (0 treated as 1)
//   Duty_Out   out WIDTH : registered duty
//   Busy       out 1     : ramp in progress
//   Done       out 1     : one-cycle pulse when Duty_Out reaches the target
// -----------------------------------------------------------------------------
module perip_duty_ramp
    import perip_pkg::*;
#(
    parameter int WIDTH = DUTY_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ramp_En,
    input  logic [WIDTH-1:0] Target_Set,
    input  logic [31:0]      Rate_Set,
    input  logic [15:0]      Step_Set,
    output logic [WIDTH-1:0] Duty_Out,
    output logic             Busy,
    output logic             Done
);

    ramp_state_e      state_q, state_d;
    logic [WIDTH-1:0] duty_q,  duty_d;
    logic [WIDTH-1:0] tgt_q,   tgt_d;
    logic [31:0]      div_q,   div_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] step_nxt_s;
    logic             step_at_tgt_s;

    perip_ramp_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur       (duty_q),
        .tgt       (tgt_q),
        .step      (Step_Set),
        .nxt       (step_nxt_s),
        .at_target (step_at_tgt_s)
    );

    // Next-state logic; priority is bypass, then retarget, then step.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        div_d   = div_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (!Ramp_En) begin
            // Bypass: follow the target directly and abort any ramp silently.
            state_d = ST_IDLE;
            duty_d  = Target_Set;
            tgt_d   = Target_Set;
            div_d   = 32'd0;
            busy_d  = 1'b0;
        end else if (Target_Set != tgt_q) begin
            // Retarget restarts the cadence and suppresses this cycle's step.
            tgt_d = Target_Set;
            div_d = 32'd0;
            if (Target_Set != duty_q) begin
                state_d = ST_RAMP;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = (state_q == ST_RAMP);
            end
        end else begin
            case (state_q)
                ST_RAMP: begin
                    if (div_q == Rate_Set) begin
                        div_d  = 32'd0;
                        duty_d = step_nxt_s;
                        if (step_at_tgt_s) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RAMP;
                        end
                    end else begin
                        div_d = div_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            div_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Duty_Out = duty_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_perip_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_perip_duty_ramp
// Table of {inputs, cycles to run, expected outputs} records plus hand-written
// sequences for retarget, mid-ramp bypass and mid-ramp reset.
// -----------------------------------------------------------------------------
module tb_perip_duty_ramp;

    logic        CLK;
    logic        RST;
    logic        Ramp_En;
    logic [31:0] Target_Set;
    logic [31:0] Rate_Set;
    logic [15:0] Step_Set;
    logic [31:0] Duty_Out;
    logic        Busy;
    logic        Done;

    int n_total;
    int n_pass;

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] tgt;
        logic [31:0] rate;
        logic [15:0] step;
        int          ncyc;
        logic [31:0] e_duty;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    perip_duty_ramp #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Ramp_En    (Ramp_En),
        .Target_Set (Target_Set),
        .Rate_Set   (Rate_Set),
        .Step_Set   (Step_Set),
        .Duty_Out   (Duty_Out),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] e_duty,
                       input logic e_busy, input logic e_done);
        n_total++;
        if (Duty_Out === e_duty && Busy === e_busy && Done === e_done) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got duty=%0d busy=%b done=%b, want duty=%0d busy=%b done=%b",
                     name, Duty_Out, Busy, Done, e_duty, e_busy, e_done);
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        RST        = 1'b1;
        Ramp_En    = 1'b1;
        Target_Set = 32'd1000;
        Rate_Set   = 32'd3;
        Step_Set   = 16'd10;

        //                rst   en    tgt      rate   step    n  duty     busy  done
        // reset, held
        vecs.push_back('{1'b1, 1'b1, 32'd1000, 32'd3, 16'd10, 1, 32'd0,   1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'd1000, 32'd3, 16'd10, 2, 32'd0,   1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd0,    32'd3, 16'd10, 1, 32'd0,   1'b0, 1'b0});
        // up ramp 0 -> 35, rate 3, step 10; edge T is the first row
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 1, 32'd0,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 2, 32'd0,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 1, 32'd0,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 1, 32'd10,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 4, 32'd20,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 4, 32'd30,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 3, 32'd30,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 1, 32'd35,  1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd35,   32'd3, 16'd10, 1, 32'd35,  1'b0, 1'b0});
        // saturating down ramp: one step of 100 from 35 lands on 0
        vecs.push_back('{1'b0, 1'b1, 32'd0,    32'd0, 16'd100,1, 32'd35,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd0,    32'd0, 16'd100,1, 32'd0,   1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd0,    32'd0, 16'd100,1, 32'd0,   1'b0, 1'b0});
        // step 0 behaves as step 1
        vecs.push_back('{1'b0, 1'b1, 32'd3,    32'd0, 16'd0,  1, 32'd0,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd3,    32'd0, 16'd0,  1, 32'd1,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd3,    32'd0, 16'd0,  1, 32'd2,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd3,    32'd0, 16'd0,  1, 32'd3,   1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd3,    32'd0, 16'd0,  1, 32'd3,   1'b0, 1'b0});
        // bypass: one-cycle latency, never busy or done
        vecs.push_back('{1'b0, 1'b0, 32'd500,  32'd0, 16'd10, 1, 32'd500, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'd500,  32'd0, 16'd10, 1, 32'd500, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'd7,    32'd0, 16'd10, 1, 32'd7,   1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd7,    32'd0, 16'd10, 1, 32'd7,   1'b0, 1'b0});

        foreach (vecs[i]) begin
            RST        = vecs[i].rst;
            Ramp_En    = vecs[i].en;
            Target_Set = vecs[i].tgt;
            Rate_Set   = vecs[i].rate;
            Step_Set   = vecs[i].step;
            tick(vecs[i].ncyc);
            chk($sformatf("vec%0d", i), vecs[i].e_duty, vecs[i].e_busy, vecs[i].e_done);
        end

        // Retarget mid-ramp: 0 -> 100, then 20 when at 40.
        Ramp_En = 1'b0; Target_Set = 32'd0; Rate_Set = 32'd0; Step_Set = 16'd10;
        tick(1);
        chk("rt_bypass0", 32'd0, 1'b0, 1'b0);
        Ramp_En = 1'b1; Target_Set = 32'd100;
        tick(1);
        chk("rt_start", 32'd0, 1'b1, 1'b0);
        tick(4);
        chk("rt_at40", 32'd40, 1'b1, 1'b0);
        Target_Set = 32'd20;
        tick(1);
        chk("rt_nostep", 32'd40, 1'b1, 1'b0);
        tick(1);
        chk("rt_30", 32'd30, 1'b1, 1'b0);
        tick(1);
        chk("rt_20done", 32'd20, 1'b0, 1'b1);
        tick(1);
        chk("rt_idle", 32'd20, 1'b0, 1'b0);

        // Retarget to the current duty mid-ramp.
        Target_Set = 32'd80;
        tick(1);
        chk("eq_start", 32'd20, 1'b1, 1'b0);
        tick(2);
        chk("eq_at40", 32'd40, 1'b1, 1'b0);
        Target_Set = 32'd40;
        tick(1);
        chk("eq_done", 32'd40, 1'b0, 1'b1);
        tick(1);
        chk("eq_idle", 32'd40, 1'b0, 1'b0);

        // Drop Ramp_En mid-ramp.
        Target_Set = 32'd90;
        tick(1);
        chk("by_start", 32'd40, 1'b1, 1'b0);
        tick(1);
        chk("by_50", 32'd50, 1'b1, 1'b0);
        Ramp_En = 1'b0;
        tick(1);
        chk("by_snap", 32'd90, 1'b0, 1'b0);
        tick(1);
        chk("by_nodone", 32'd90, 1'b0, 1'b0);

        // Reset mid-ramp at 50, then restart from 0 toward an unchanged 50.
        Target_Set = 32'd0;
        tick(1);
        Ramp_En = 1'b1; Target_Set = 32'd100;
        tick(6);
        chk("rs_at50", 32'd50, 1'b1, 1'b0);
        RST = 1'b1; Target_Set = 32'd50;
        tick(1);
        chk("rs_zero", 32'd0, 1'b0, 1'b0);
        RST = 1'b0;
        tick(1);
        chk("rs_restart", 32'd0, 1'b1, 1'b0);
        tick(1);
        chk("rs_10", 32'd10, 1'b1, 1'b0);
        tick(4);
        chk("rs_done", 32'd50, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
